wallace_pipe_mult: RTL

- Parametrised, pipelined successor to the 8-bit combinational Wallace-tree multiplier.
- Computes a WIDTH x WIDTH product through a 3-stage pipeline:
  - stage 1: partial-product generation plus the first Wallace reduction levels;
  - stage 2: remaining 3:2 reduction down to two rows;
  - stage 3: final carry-propagate add.
- Adds valid/ready handshakes on both sides, per-operation signed/unsigned mode and an in-flight counter.
- Sits between operand sources and result consumers in the arithmetic datapath.

---
 rtl/wallace_pipe_mult.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wallace_pipe_mult.sv
// Three-stage pipelined WIDTH x WIDTH multiplier: Baugh-Wooley partial products reduced by a
// carry-save (3:2) Wallace tree, then a final carry-propagate add, with valid/ready on both sides.
module wallace_pipe_mult #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic [CNT_W-1:0]   in_flight
);

   localparam int PW = 2 * WIDTH;
   localparam int R0 = WIDTH + 1;

   function automatic int nextRows(input int n);
      return (n / 3) * 2 + (n % 3);
   endfunction

   function automatic int levelsToTwo(input int n);
      int rows = n;
      int lv   = 0;
      for (int k = 0; k < 32; k++) begin
         if (rows > 2) begin
            rows = nextRows(rows);
            lv++;
         end
      end
      return lv;
   endfunction

   function automatic int rowsAfter(input int n, input int levels);
      int rows = n;
      for (int k = 0; k < 32; k++) begin
         if (k < levels) rows = nextRows(rows);
      end
      return rows;
   endfunction

   // Stage 1 takes the larger half of the reduction levels; stage 3 is the carry-propagate add.
   localparam int LV  = levelsToTwo(R0);
   localparam int LV1 = (LV + 1) / 2;
   localparam int LV2 = LV - LV1;
   localparam int R1  = rowsAfter(R0, LV1);

   typedef logic [R0-1:0][PW-1:0] rows_t;
   typedef logic [1:0][PW-1:0]    pair_t;

   // Each level compresses groups of three rows into a sum row and a shifted carry row.
   function automatic rows_t csaLevels(input rows_t rowsIn, input int nIn, input int levels);
      rows_t cur;
      rows_t nxt;
      int    n;
      int    full;
      cur = rowsIn;
      n   = nIn;
      for (int l = 0; l < LV; l++) begin
         if (l < levels) begin
            nxt  = '0;
            full = n / 3;
            for (int g = 0; g < R0 / 3; g++) begin
               if (g < full) begin
                  nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                  nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                                (cur[3*g+1] & cur[3*g+2])) << 1;
               end
            end
            for (int k = 0; k < R0; k++) begin
               if (k >= 3 * full && k < n) nxt[k-full] = cur[k];
            end
            cur = nxt;
            n   = n - full;
         end
      end
      return cur;
   endfunction

   function automatic pair_t reduceToTwo(input rows_t rowsIn);
      rows_t r;
      r = csaLevels(rowsIn, R1, LV2);
      return r[1:0];
   endfunction

   logic             adv;
   rows_t            ppRows;
   rows_t            s1Rows_d;
   rows_t            s1Rows_q;
   pair_t            s2Rows_d;
   pair_t            s2Rows_q;
   logic [PW-1:0]    product_d;
   logic [PW-1:0]    product_q;
   logic             s1Valid_q;
   logic             s2Valid_q;
   logic             outValid_q;
   logic             inXfer;
   logic             outXfer;
   logic [CNT_W-1:0] inFlight_d;
   logic [CNT_W-1:0] inFlight_q;

   assign adv     = !outValid_q || out_ready;
   assign inXfer  = in_valid && adv;
   assign outXfer = outValid_q && out_ready;

   // Signed mode inverts the terms with exactly one MSB operand and adds 2^WIDTH + 2^(PW-1).
   always_comb begin
      ppRows = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            ppRows[i][i+j] = (a[j] & b[i]) ^
                             (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
         end
      end
      if (signed_mode) begin
         ppRows[WIDTH][WIDTH]  = 1'b1;
         ppRows[WIDTH][PW-1]   = 1'b1;
      end
      s1Rows_d = csaLevels(ppRows, R0, LV1);
   end

   always_comb begin
      s2Rows_d  = reduceToTwo(s1Rows_q);
      product_d = s2Rows_q[0] + s2Rows_q[1];
   end

   always_comb begin
      inFlight_d = inFlight_q;
      if (inXfer && !outXfer) begin
         inFlight_d = inFlight_q + CNT_W'(1);
      end else if (!inXfer && outXfer) begin
         inFlight_d = inFlight_q - CNT_W'(1);
      end
   end

   // The whole pipe advances together; data registers only load behind a valid bit so the
   // product output keeps its last real value through bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q  <= 1'b0;
         s1Rows_q   <= '0;
         s2Valid_q  <= 1'b0;
         s2Rows_q   <= '0;
         outValid_q <= 1'b0;
         product_q  <= '0;
         inFlight_q <= '0;
      end else begin
         inFlight_q <= inFlight_d;
         if (adv) begin
            s1Valid_q  <= in_valid;
            s2Valid_q  <= s1Valid_q;
            outValid_q <= s2Valid_q;
            if (in_valid)  s1Rows_q  <= s1Rows_d;
            if (s1Valid_q) s2Rows_q  <= s2Rows_d;
            if (s2Valid_q) product_q <= product_d;
         end
      end
   end

   assign in_ready  = adv;
   assign out_valid = outValid_q;
   assign product   = product_q;
   assign in_flight = inFlight_q;

endmodule
